// File: rtl/span_queue_writer.sv
// span_queue_writer
//   Converts rectangle commands into 2-word span records (one per row, in
//   ascending row order) and writes them into a circular PRAM queue that a
//   painter consumes. The write pointer is published only after both words
//   of a record are in memory, so the consumer never sees half a record.
//
//   Optional feature: define SPAN_CLIP_EN to skip rows below MAX_Y
//   (rows with index > MAX_Y are dropped and the command ends there).
//
// Ports
//   clk, reset            clock (rising edge), synchronous active-high reset
//   cmd_valid/cmd_ready   rectangle command handshake
//   cmd_x0/x1, cmd_y0/y1  inclusive endpoints, any order (7 bits each)
//   cmd_color             3-bit RGB colour
//   rdPtr                 consumer read pointer into the PRAM queue
//   wrtPtr                committed write pointer (next free word)
//   pram_we/addr/din      PRAM write port (addr/din are 0 when not writing)
//   busy                  high whenever the FSM is not idle
//   dbg_state_o           current FSM state for observation
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only while idle and out of
// reset; cmd_valid may be held or dropped freely, and command fields are
// sampled only at the transfer edge.

module span_queue_writer #(
    parameter int ADDR_W = 10,
    parameter int MAX_Y  = 119
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [6:0]        cmd_x0,
    input  logic [6:0]        cmd_x1,
    input  logic [6:0]        cmd_y0,
    input  logic [6:0]        cmd_y1,
    input  logic [2:0]        cmd_color,
    input  logic [ADDR_W-1:0] rdPtr,
    output logic [ADDR_W-1:0] wrtPtr,
    output logic [ADDR_W-1:0] pram_addr,
    output logic [15:0]       pram_din,
    output logic              pram_we,
    output logic              busy,
    output logic [2:0]        dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_WR1    = 3'd2,
        S_WR2    = 3'd3,
        S_COMMIT = 3'd4
    } state_t;

`ifdef SPAN_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif
    localparam logic [6:0] MAX_Y_L = 7'(MAX_Y);

    state_t            state_q;
    logic [6:0]        left_q;
    logic [6:0]        right_q;
    logic [6:0]        y_hi_q;
    logic [6:0]        cur_y_q;
    logic [2:0]        color_q;
    logic [ADDR_W-1:0] wrtptr_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       din_q;

    // Normalised command fields, sampled only at acceptance.
    logic [6:0] left_d, right_d, y_lo_d, y_hi_d;
    assign left_d  = (cmd_x0 < cmd_x1) ? cmd_x0 : cmd_x1;
    assign right_d = (cmd_x0 < cmd_x1) ? cmd_x1 : cmd_x0;
    assign y_lo_d  = (cmd_y0 < cmd_y1) ? cmd_y0 : cmd_y1;
    assign y_hi_d  = (cmd_y0 < cmd_y1) ? cmd_y1 : cmd_y0;

    // Free words between our committed pointer and the consumer; one slot
    // is always kept empty so full and empty are distinguishable.
    logic [ADDR_W-1:0] free_w;
    assign free_w = rdPtr - wrtptr_q - ADDR_W'(1);

    logic [15:0] word1_w, word2_w;
    assign word1_w = {2'b00, left_q, right_q};
    assign word2_w = {6'b000000, cur_y_q, color_q};

    logic row_clipped;
    assign row_clipped = CLIP_EN && (cur_y_q > MAX_Y_L);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            left_q   <= '0;
            right_q  <= '0;
            y_hi_q   <= '0;
            cur_y_q  <= '0;
            color_q  <= '0;
            wrtptr_q <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
        end else begin
            // Write port is registered: it is loaded on the edge entering
            // WR1/WR2 and returns to zero in every other state.
            we_q   <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        left_q  <= left_d;
                        right_q <= right_d;
                        y_hi_q  <= y_hi_d;
                        cur_y_q <= y_lo_d;
                        color_q <= cmd_color;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Rows only increase, so once one is clipped all are.
                    if (row_clipped) begin
                        state_q <= S_IDLE;
                    end else if (free_w >= ADDR_W'(2)) begin
                        we_q    <= 1'b1;
                        addr_q  <= wrtptr_q;
                        din_q   <= word1_w;
                        state_q <= S_WR1;
                    end
                end
                S_WR1: begin
                    we_q    <= 1'b1;
                    addr_q  <= wrtptr_q + ADDR_W'(1);
                    din_q   <= word2_w;
                    state_q <= S_WR2;
                end
                S_WR2: begin
                    state_q <= S_COMMIT;
                end
                S_COMMIT: begin
                    wrtptr_q <= wrtptr_q + ADDR_W'(2);
                    if (cur_y_q == y_hi_q) begin
                        state_q <= S_IDLE;
                    end else begin
                        cur_y_q <= cur_y_q + 7'd1;
                        state_q <= S_WAIT;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = (state_q == S_IDLE) && !reset;
    assign busy        = (state_q != S_IDLE);
    assign wrtPtr      = wrtptr_q;
    assign pram_we     = we_q;
    assign pram_addr   = addr_q;
    assign pram_din    = din_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_span_queue_writer.sv
// Directed bench for span_queue_writer (ADDR_W = 10, MAX_Y = 119).
module tb_span_queue_writer;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [6:0]    cmd_x0, cmd_x1, cmd_y0, cmd_y1;
    logic [2:0]    cmd_color;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_tb;
    logic          track;
    logic [AW-1:0] wrt_ptr;
    logic [AW-1:0] pram_addr;
    logic [15:0]   pram_din;
    logic          pram_we;
    logic          busy;
    logic [2:0]    dbg_state;

    int n_asserts = 0;
    int n_fails   = 0;

    // Observed writes and expected writes (scoreboard).
    logic [AW-1:0] wa_q[$];
    logic [15:0]   wd_q[$];
    logic [AW-1:0] exp_a_q[$];
    logic [15:0]   exp_q[$];

    // Consumer model: either a fixed pointer or one that follows wrtPtr.
    assign rd_ptr = track ? wrt_ptr : rd_tb;

    span_queue_writer #(.ADDR_W(AW), .MAX_Y(119)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_x0      (cmd_x0),
        .cmd_x1      (cmd_x1),
        .cmd_y0      (cmd_y0),
        .cmd_y1      (cmd_y1),
        .cmd_color   (cmd_color),
        .rdPtr       (rd_ptr),
        .wrtPtr      (wrt_ptr),
        .pram_addr   (pram_addr),
        .pram_din    (pram_din),
        .pram_we     (pram_we),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Write monitor
    always @(negedge clk) begin
        if (pram_we) begin
            wa_q.push_back(pram_addr);
            wd_q.push_back(pram_din);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fails++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("check %s disagreed", tag);
        end
    endtask

    task automatic clear_q();
        wa_q.delete();
        wd_q.delete();
        exp_a_q.delete();
        exp_q.delete();
    endtask

    task automatic expect_rec(input logic [AW-1:0] a, input logic [15:0] w1, input logic [15:0] w2);
        exp_a_q.push_back(a);
        exp_q.push_back(w1);
        exp_a_q.push_back(a + AW'(1));
        exp_q.push_back(w2);
    endtask

    task automatic check_writes(input string tag);
        int n;
        check({tag, "_count"}, wa_q.size(), exp_q.size());
        n = (wa_q.size() < exp_q.size()) ? wa_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_addr%0d", tag, i), wa_q[i], exp_a_q[i]);
            check($sformatf("%s_data%0d", tag, i), wd_q[i], exp_q[i]);
        end
        clear_q();
    endtask

    // Driver tasks
    task automatic do_reset();
        reset     = 1'b1;
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_wrtptr", wrt_ptr, 0);
        check("rst_we", pram_we, 0);
        check("rst_addr", pram_addr, 0);
        check("rst_din", pram_din, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", cmd_ready, 0);
        reset = 1'b0;
        #1;
        check("rst_ready_after", cmd_ready, 1);
        clear_q();
    endtask

    task automatic issue(input logic [6:0] x0, input logic [6:0] x1,
                         input logic [6:0] y0, input logic [6:0] y1, input logic [2:0] c);
        cmd_x0    = x0;
        cmd_x1    = x1;
        cmd_y0    = y0;
        cmd_y1    = y1;
        cmd_color = c;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_x0    = 7'h55;
        cmd_x1    = 7'h2a;
        cmd_y0    = 7'h7f;
        cmd_y1    = 7'h00;
        cmd_color = 3'd0;
    endtask

    task automatic wait_idle(input string tag, input int budget, output int cycles);
        cycles = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            cycles++;
            if (!busy) break;
        end
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int cyc;
        logic [AW-1:0] a;
        logic [AW-1:0] pre;
        int last_row;

        track     = 1'b0;
        rd_tb     = '0;
        cmd_valid = 1'b0;
        cmd_x0    = '0;
        cmd_x1    = '0;
        cmd_y0    = '0;
        cmd_y1    = '0;
        cmd_color = '0;
        reset     = 1'b1;

        // Single-row rectangle, cycle by cycle.
        do_reset();
        issue(7'd10, 7'd20, 7'd5, 7'd5, 3'd3);
        check("t1_wait_we", pram_we, 0);
        check("t1_wait_busy", busy, 1);
        @(negedge clk);
        check("t1_wr1_we", pram_we, 1);
        check("t1_wr1_addr", pram_addr, 0);
        check("t1_wr1_din", pram_din, 16'h0514);
        @(negedge clk);
        check("t1_wr2_we", pram_we, 1);
        check("t1_wr2_addr", pram_addr, 1);
        check("t1_wr2_din", pram_din, 16'h002B);
        check("t1_wr2_ptr", wrt_ptr, 0);
        @(negedge clk);
        check("t1_cm_we", pram_we, 0);
        check("t1_cm_addr", pram_addr, 0);
        check("t1_cm_din", pram_din, 0);
        check("t1_cm_ptr", wrt_ptr, 0);
        @(negedge clk);
        check("t1_ptr", wrt_ptr, 2);
        check("t1_busy", busy, 0);
        check("t1_ready", cmd_ready, 1);
        clear_q();

        // Swapped endpoints, three rows, 4 cycles per row.
        issue(7'd20, 7'd10, 7'd7, 7'd5, 3'd1);
        wait_idle("t2", 50, cyc);
        check("t2_cycles", cyc, 12);
        expect_rec(10'd2, 16'h0514, 16'h0029);
        expect_rec(10'd4, 16'h0514, 16'h0031);
        expect_rec(10'd6, 16'h0514, 16'h0039);
        check_writes("t2");
        check("t2_ptr", wrt_ptr, 8);

        // Queue full: free = 1 with rdPtr = 2, then space opens.
        rd_tb = 10'd2;
        do_reset();
        issue(7'd2, 7'd1, 7'd0, 7'd0, 3'd4);
        repeat (5) @(negedge clk);
        check("t3_state_wait", dbg_state, 1);
        check("t3_we", pram_we, 0);
        check("t3_nowrite", wa_q.size(), 0);
        check("t3_ptr_hold", wrt_ptr, 0);
        rd_tb = 10'd3;
        wait_idle("t3", 20, cyc);
        expect_rec(10'd0, 16'h0082, 16'h0004);
        check_writes("t3");
        check("t3_ptr", wrt_ptr, 2);

        // Wrap across the top of the queue with a tracking consumer.
        track = 1'b1;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            issue(7'd0, 7'd0, 7'd0, 7'd127, 3'd0);
            wait_idle("t4_fill", 600, cyc);
        end
        issue(7'd0, 7'd0, 7'd0, 7'd126, 3'd0);
        wait_idle("t4_fill", 600, cyc);
        check("t4_ptr_pre", wrt_ptr, 1022);
        clear_q();
        issue(7'd0, 7'd127, 7'd9, 7'd9, 3'd2);
        wait_idle("t4", 20, cyc);
        expect_rec(10'd1022, 16'h007F, 16'h004A);
        check_writes("t4");
        check("t4_ptr", wrt_ptr, 0);

        // Rows 118..125: clipped at 119 only when the clip feature is built in.
`ifdef SPAN_CLIP_EN
        last_row = 119;
`else
        last_row = 125;
`endif
        issue(7'd3, 7'd4, 7'd125, 7'd118, 3'd7);
        wait_idle("t5", 80, cyc);
        a = '0;
        for (int r = 118; r <= last_row; r++) begin
            expect_rec(a, 16'h0184, 16'((r << 3) | 7));
            a = a + AW'(2);
        end
        check_writes("t5");
        check("t5_ptr", wrt_ptr, 32'(a));

        // Reset during WR2 of a 3-row command.
        clear_q();
        issue(7'd0, 7'd1, 7'd0, 7'd2, 3'd5);
        for (int i = 0; i < 10; i++) begin
            if (dbg_state == 3'd3) break;
            @(negedge clk);
        end
        check("t6_in_wr2", dbg_state, 3);
        pre = wrt_ptr;
        reset = 1'b1;
        @(negedge clk);
        check("t6_we", pram_we, 0);
        check("t6_ptr", wrt_ptr, 0);
        check("t6_busy", busy, 0);
        check("t6_state", dbg_state, 0);
        check("t6_ready_in_rst", cmd_ready, 0);
        reset = 1'b0;
        #1;
        check("t6_ready", cmd_ready, 1);
        check("t6_partial_writes", wa_q.size(), 2);
        if (wa_q.size() > 0) check("t6_partial_addr", wa_q[0], pre);
        repeat (3) @(negedge clk);
        check("t6_idle_after", busy, 0);
        clear_q();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule

// File: doc/span_queue_writer.md
SPAN_QUEUE_WRITER -- requirements
Module: span_queue_writer

Interface
REQ-001 Parameter ADDR_W, default 10, PRAM queue address width (queue depth 2^ADDR_W words).
REQ-002 Parameter MAX_Y, default 119, last visible row index, used only when SPAN_CLIP_EN is defined.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 cmd_valid  input  1  rectangle command present.
REQ-006 cmd_ready  output  1  block accepts a command this cycle.
REQ-007 cmd_x0, cmd_x1  input  7 each  horizontal span endpoints, inclusive, any order.
REQ-008 cmd_y0, cmd_y1  input  7 each  vertical row endpoints, inclusive, any order.
REQ-009 cmd_color  input  3  RGB color.
REQ-010 rdPtr  input  ADDR_W  consumer (painter) read pointer into PRAM.
REQ-011 wrtPtr  output  ADDR_W  committed write pointer; next free PRAM word.
REQ-012 pram_addr  output  ADDR_W  PRAM write address.
REQ-013 pram_din  output  16  PRAM write data.
REQ-014 pram_we  output  1  PRAM write strobe.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 Block SHALL convert each accepted rectangle into one 2-word span record per row, written in ascending row order.
REQ-017 Word 1 SHALL be {2'b00, left[6:0], right[6:0]}; word 2 SHALL be {6'b0, row[6:0], color[2:0]}.
REQ-018 On acceptance, left=min(x0,x1), right=max(x0,x1), y_lo=min(y0,y1), y_hi=max(y0,y1), color SHALL be latched; cmd inputs are ignored thereafter.
REQ-019 cmd_ready SHALL equal (state==IDLE) and not reset; acceptance = cmd_valid & cmd_ready.
REQ-020 States: IDLE, WAIT, WR1, WR2, COMMIT.
REQ-021 IDLE: on acceptance, cur_y<=y_lo, go WAIT.
REQ-022 WAIT: free = (rdPtr - wrtPtr - 1) mod 2^ADDR_W; if free>=2 go WR1, else stay with pram_we=0.
REQ-023 WR1: pram_we=1, pram_addr=wrtPtr, pram_din=word 1; go WR2.
REQ-024 WR2: pram_we=1, pram_addr=(wrtPtr+1) mod 2^ADDR_W, pram_din=word 2; go COMMIT.
REQ-025 COMMIT: wrtPtr<=(wrtPtr+2) mod 2^ADDR_W; if cur_y==y_hi go IDLE, else cur_y<=cur_y+1, go WAIT.
REQ-026 wrtPtr SHALL change only in COMMIT, so the consumer never observes a half-written record.
REQ-027 pram_we SHALL be 0 in IDLE, WAIT, COMMIT; pram_addr/pram_din SHALL be 0 when pram_we=0.
REQ-028 Minimum throughput: 4 cycles per row when space available; first pram_we 2 cycles after acceptance.
REQ-029 Pointer arithmetic SHALL wrap modulo 2^ADDR_W; record may straddle address 2^ADDR_W-1 -> 0.
REQ-030 Queue is full when free<2; block SHALL never write a location in [rdPtr, wrtPtr) uncommitted by consumer.
REQ-031 Degenerate rectangles (x0==x1 and/or y0==y1) SHALL produce exactly (y_hi-y_lo+1) records.

Reset
REQ-032 reset SHALL force state=IDLE, wrtPtr=0, pram_we=0, pram_addr=0, pram_din=0, busy=0, cmd_ready=0 during reset.
REQ-033 Reset mid-command SHALL abandon remaining rows; uncommitted record writes SHALL not advance wrtPtr beyond value held at reset entry, then 0.
REQ-034 Block and consumer SHALL be reset together so both pointers start at 0.

Configuration
REQ-035 Macro SPAN_CLIP_EN: when defined, rows with cur_y>MAX_Y SHALL be skipped: WAIT with cur_y>MAX_Y goes IDLE with no write; a command with y_lo>MAX_Y returns to IDLE one cycle after acceptance with no write.
REQ-036 Without SPAN_CLIP_EN, all rows 0..127 SHALL be written unmodified.

Verification
REQ-037 Reset, rdPtr=0; cmd x0=10,x1=20,y0=y1=5,color=3 -> writes addr0=0x0514, addr1=0x002B, wrtPtr=2 after COMMIT, back to IDLE.
REQ-038 cmd x0=20,x1=10,y0=7,y1=5,color=1 -> three records rows 5,6,7, word1=0x0514 each, word2=0x0029,0x0031,0x0039, wrtPtr advances by 6.
REQ-039 After reset hold rdPtr=2; issue 1-row cmd -> stays in WAIT with pram_we=0 (free=1); rdPtr->3 -> record written at addr 0,1.
REQ-040 Consumer tracks wrtPtr; issue spans until wrtPtr=1022; next span -> writes addr 1022,1023, wrtPtr=0.
REQ-041 cmd y0=118,y1=125 -> with SPAN_CLIP_EN 2 records (rows 118,119); without, 8 records.
REQ-042 Assert reset during WR2 of a 3-row cmd -> pram_we=0 next cycle, wrtPtr=0, cmd_ready=1 first cycle after reset release.
